// File: rtl/dct_mem_sequencer.sv
// Sequences one DCT pass: streams input-SRAM words into DCT_UNIT and writes results to output SRAM.
// Latency: reads start the cycle after start, writes start PIPE_LAT cycles later, done at PIPE_LAT+W.
// No backpressure: one word per cycle each side; start is ignored while busy or done.
// Optional macro DCT_SEQ_PERF_EN adds the pass_cycles busy-cycle counter output.
module dct_mem_sequencer #(
   parameter int N_BLOCKS = 1024,   // 16-word blocks per pass, 1..1024
   parameter int RD_LAT   = 2,      // read address -> DCT input, >= 1
   parameter int PIPE_LAT = 36      // read address -> output SRAM write, >= RD_LAT+1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       NCE_IN,
   output logic       NWRT_IN,
   output logic [9:0] RA_IN,
   output logic [3:0] CA_IN,
   output logic       NCE_OUT,
   output logic       NWRT_OUT,
   output logic [9:0] RA_OUT,
   output logic [3:0] CA_OUT,
   output logic       dct_flag,
   output logic       dct_en
`ifdef DCT_SEQ_PERF_EN
   ,
   output logic [19:0] pass_cycles
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   // Final word address of a pass on both the read and the write side.
   localparam logic [13:0] LAST_ADDR = 14'(N_BLOCKS * 16 - 1);

   // Launch counter only needs to reach PIPE_LAT, then it parks there.
   localparam int             LW         = $clog2(PIPE_LAT + 1);
   localparam logic [LW-1:0] LAUNCH_CNT = LW'(PIPE_LAT - 1);
   localparam logic [LW-1:0] LAT_DONE   = LW'(PIPE_LAT);

   logic [1:0]        state_q, state_d;
   logic              rd_act_q, rd_act_d;
   logic [13:0]       rd_addr_q, rd_addr_d;
   logic              wr_act_q, wr_act_d;
   logic [13:0]       wr_addr_q, wr_addr_d;
   logic [LW-1:0]     lat_q, lat_d;
   logic [RD_LAT-1:0] en_sr_q, en_sr_d;
   logic [RD_LAT-1:0] bnd_sr_q, bnd_sr_d;
   logic              flag_q, flag_d;

   // Pass control: read counter, write launch timer, write counter and state transitions.
   always_comb begin
      state_d   = state_q;
      rd_act_d  = rd_act_q;
      rd_addr_d = rd_addr_q;
      wr_act_d  = wr_act_q;
      wr_addr_d = wr_addr_q;
      lat_d     = lat_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RUN;
               rd_act_d  = 1'b1;
               rd_addr_d = 14'd0;
               lat_d     = '0;
            end
         end
         S_RUN: begin
            // Read side: one address per cycle, stop and hold on the last word.
            if (rd_act_q) begin
               if (rd_addr_q == LAST_ADDR) begin
                  rd_act_d = 1'b0;
               end else begin
                  rd_addr_d = rd_addr_q + 14'd1;
               end
            end
            // Write side opens exactly PIPE_LAT cycles after the first read.
            if (lat_q != LAT_DONE) begin
               lat_d = lat_q + LW'(1);
               if (lat_q == LAUNCH_CNT) begin
                  wr_act_d  = 1'b1;
                  wr_addr_d = 14'd0;
               end
            end
            // The last write issued closes the pass.
            if (wr_act_q) begin
               if (wr_addr_q == LAST_ADDR) begin
                  wr_act_d = 1'b0;
                  state_d  = S_FIN;
               end else begin
                  wr_addr_d = wr_addr_q + 14'd1;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // DCT-side timing: delay read activity and block-start markers by RD_LAT.
   always_comb begin
      // en_sr_q[j] holds rd_act from j+1 cycles ago; bnd_sr_q[j] holds the
      // "word at CA=0 being read" marker from j cycles ago (fed from next-state).
      en_sr_d[0]  = rd_act_q;
      bnd_sr_d[0] = rd_act_d && (rd_addr_d[3:0] == 4'd0);
      for (int i = 1; i < RD_LAT; i++) begin
         en_sr_d[i]  = en_sr_q[i-1];
         bnd_sr_d[i] = bnd_sr_q[i-1];
      end
      // Toggle on the edge that brings a block's first word into the DCT.
      flag_d = flag_q ^ bnd_sr_q[RD_LAT-1];
   end

   // State and counter registers; reset drops all SRAM controls immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rd_act_q  <= 1'b0;
         rd_addr_q <= 14'd0;
         wr_act_q  <= 1'b0;
         wr_addr_q <= 14'd0;
         lat_q     <= '0;
         en_sr_q   <= '0;
         bnd_sr_q  <= '0;
         flag_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_act_q  <= rd_act_d;
         rd_addr_q <= rd_addr_d;
         wr_act_q  <= wr_act_d;
         wr_addr_q <= wr_addr_d;
         lat_q     <= lat_d;
         en_sr_q   <= en_sr_d;
         bnd_sr_q  <= bnd_sr_d;
         flag_q    <= flag_d;
      end
   end

`ifdef DCT_SEQ_PERF_EN
   logic [19:0] pass_cycles_q, pass_cycles_d;

   // Busy-cycle counter: cleared by an accepted start, held after the pass.
   always_comb begin
      pass_cycles_d = pass_cycles_q;
      if (state_q == S_IDLE && start) begin
         pass_cycles_d = 20'd0;
      end else if (state_q == S_RUN) begin
         pass_cycles_d = pass_cycles_q + 20'd1;
      end
   end

   // Performance counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pass_cycles_q <= 20'd0;
      end else begin
         pass_cycles_q <= pass_cycles_d;
      end
   end

   assign pass_cycles = pass_cycles_q;
`endif

   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_FIN);
   assign NCE_IN   = ~rd_act_q;
   assign NWRT_IN  = 1'b1;
   assign RA_IN    = rd_addr_q[13:4];
   assign CA_IN    = rd_addr_q[3:0];
   assign NCE_OUT  = ~wr_act_q;
   assign NWRT_OUT = ~wr_act_q;
   assign RA_OUT   = wr_addr_q[13:4];
   assign CA_OUT   = wr_addr_q[3:0];
   assign dct_flag = flag_q;
   assign dct_en   = en_sr_q[RD_LAT-1];

endmodule
